spi_master_mc: RTL and testbench
================================

Name: spi_master_mc

Overview:
Multi-chip-select SPI master and successor to the fixed-mode SPI master.
- SPI mode (CPOL/CPHA), bit order, word length and SCK divider are all selected at runtime, per transfer.
- Drives up to NCS active-low chip selects and can hold CS across a burst of words.
- Sits between a register/CPU bus bridge and external SPI devices (flash, ADC, SD).
- Keeps the toggle req/ack handshake.

Parameters:
MAXB, 32, maximum word length in bits (>=2).
NCS, 4, number of chip-select outputs (>=1).
DIVW, 8, width of the runtime divider input.
CSW, 2, width of the CS setup/hold/gap counters.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
sclk  out  1  SPI clock.
mosi  out  1  SPI data out.
miso  in  1  SPI data in (asynchronous).
cs_n  out  NCS  active-low chip selects.
req  in  1  toggle request; a transfer is pending when req != ack.
ack  out  1  set to req when a word completes.
cs_sel  in  max(1,$clog2(NCS))  target chip select.
cpol  in  1  clock polarity.
cpha  in  1  clock phase.
lsb_first  in  1  bit order.
nbits  in  $clog2(MAXB+1)  word length; 0 or >MAXB is clamped to MAXB, 1 is clamped to 2.
div  in  DIVW  SCK half-period = div+1 clk cycles.
cs_setup  in  CSW  extra half-periods between CS assert and the first edge.
hold_cs  in  1  keep CS asserted after this word.
d  in  MAXB  transmit word, right-aligned (bits nbits-1:0).
q  out  MAXB  received word, right-aligned, upper bits zero.
busy  out  1  high while the FSM is not IDLE.

Behaviour:
- Reset values: sclk=0, mosi=0, all cs_n=1, ack=0, q=0, busy=0, state IDLE. Reset mid-transfer aborts immediately and releases CS the next cycle.
- Tick generator: counter reloads to the latched div; an event fires when it reaches 0. All FSM advances occur only on ticks.
- miso passes through one sync flop; samples use the synchronised value.
- Transfer start (IDLE, req != ack): latch cs_sel, cpol, cpha, lsb_first, nbits, div, cs_setup, hold_cs and d.
  - sclk = cpol.
  - mosi = first bit (d[nbits-1] when MSB-first, d[0] when LSB-first).
  - Assert the selected cs_n.
  - Go to SETUP.
- SETUP: wait cs_setup+1 ticks, then go to SHIFT with edge counter = 0.
- SHIFT: each tick toggles sclk and increments the edge counter, for 2*nbits edges.
  - Sampling edge: leading edge if cpha=0, trailing edge if cpha=1; shift miso_sync into the receive register.
  - Shift edge: the opposite edge; shift transmit data (mosi=0 after the last bit).
  - cpha=1: the first leading edge only presents the first bit; the sampling and shift edges swap roles.
  - After edge 2*nbits (sclk back at cpol):
    - q <= received word, right-aligned with upper bits zeroed.
    - ack <= req. q is valid in the same cycle ack changes.
    - Go to TAIL.
- TAIL: one tick of CS hold. Then:
  - if latched hold_cs=1, go to HOLD with CS still asserted;
  - otherwise deassert CS and go to GAP.
- HOLD: CS stays asserted, sclk = cpol.
  - New req with the same cs_sel, cpol and cpha: latch the new config and go directly to SHIFT with no setup. lsb_first, nbits and div may change.
  - New req with a different cs_sel/cpol/cpha: deassert CS, go to GAP, then start normally.
  - hold_cs is not sampled while in HOLD; software releases CS by issuing a word with hold_cs=0.
- GAP: CS deasserted for cs_setup+1 ticks, then IDLE. A pending req is serviced on the next tick.
- req toggling again before ack is ignored until completion (level-compare semantics). Inputs other than req are only sampled at latch points.
- div=0: half-period of 1 clk; SCK = clk/2.

Optional Feature:
SPI_MASTER_MC_LOOPBACK_EN
- Defined: adds input port loopback (1 bit). When loopback=1, the sync flop takes mosi instead of miso, so q equals the transmitted word. sclk and cs_n still toggle.
- Undefined: no port, no mux; miso is used directly.

Decomposition:
- Package spi_mc_pkg holds:
  - state enum (IDLE, SETUP, SHIFT, TAIL, HOLD, GAP);
  - function clog2_floor1 (floor(log2)+1);
  - nbits clamp function;
  - localparam CNTW = $clog2(2*MAXB+1).
- One sub-module, spi_mc_tick_gen: loadable down-counter with DIVW-bit reload and a tick output, cleared by reset/start.

Test Plan:
- Mode 0, MSB-first, nbits=8, div=3, d=8'hA5, slave returns 8'h3C: mosi bits 1,0,1,0,0,1,0,1; 8 rising edges at 8-clk period; q=32'h3C; ack toggles once; cs_n[cs_sel] low for the whole transfer, high afterwards.
- Mode 3, LSB-first, nbits=12, d=12'h123, loopback model: idle sclk=1; first bit d[0]=1; q=32'h123.
- Burst of three words with hold_cs=1,1,0 on cs_sel=2, same mode: cs_n[2] stays low across all 24 bits with no setup between words; it rises after the third word; exactly three ack toggles.
- hold_cs=1 on cs0, then next req targets cs1: cs_n[0] rises, GAP of cs_setup+1 ticks, then cs_n[1] falls; never both low.
- Reset asserted at edge 5 of a 16-bit transfer: next cycle cs_n all 1, sclk=0, busy=0, ack unchanged from its pre-reset value (0); a new req completes correctly.
- Clamping: nbits=0 -> 32 bits shifted; nbits=1 -> 2 bits; div=0 -> sclk period 2 clk.

Source files
------------

// File: rtl/spi_mc_pkg.sv
// spi_mc_pkg: shared FSM states and sizing helpers for the multi-CS SPI master
package spi_mc_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, TAIL, HOLD, GAP} state_t;
  localparam int DEF_MAXB = 32;
  localparam int CNTW = $clog2(2*DEF_MAXB+1);
  function automatic int clog2_floor1(input int v);
    int r, x;
    r = 0;
    x = v;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction
  function automatic int clamp_nbits(input int n, input int maxb);
    return (n == 0 || n > maxb) ? maxb : (n == 1 ? 2 : n);
  endfunction
endpackage

// File: rtl/spi_mc_tick_gen.sv
// spi_mc_tick_gen: reloadable down-counter producing one tick every div+1 clocks
module spi_mc_tick_gen #(
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [DIVW-1:0] div,
  output logic            tick
);
  logic [DIVW-1:0] cnt, rel;
  assign tick = cnt == '0 && !load && !reset;
  // count down, reloading from the divider captured at the last load
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      rel <= '0;
    end else if (load) begin
      cnt <= div;
      rel <= div;
    end else
      cnt <= cnt == '0 ? rel : cnt - 1'b1;
endmodule

// File: rtl/spi_master_mc.sv
// spi_master_mc: runtime-configurable SPI master with NCS chip selects and CS burst hold; SPI_MASTER_MC_LOOPBACK_EN adds a mosi->miso loopback port
module spi_master_mc
  import spi_mc_pkg::*;
#(
  parameter int MAXB = 32,
  parameter int NCS  = 4,
  parameter int DIVW = 8,
  parameter int CSW  = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  output logic                              sclk,
  output logic                              mosi,
  input  logic                              miso,
`ifdef SPI_MASTER_MC_LOOPBACK_EN
  input  logic                              loopback,
`endif
  output logic [NCS-1:0]                    cs_n,
  input  logic                              req,
  output logic                              ack,
  input  logic [(NCS>1?$clog2(NCS):1)-1:0]  cs_sel,
  input  logic                              cpol,
  input  logic                              cpha,
  input  logic                              lsb_first,
  input  logic [$clog2(MAXB+1)-1:0]         nbits,
  input  logic [DIVW-1:0]                   div,
  input  logic [CSW-1:0]                    cs_setup,
  input  logic                              hold_cs,
  input  logic [MAXB-1:0]                   d,
  output logic [MAXB-1:0]                   q,
  output logic                              busy
);
  localparam int NBW = clog2_floor1(MAXB);
  localparam int EW  = clog2_floor1(2*MAXB);
  localparam int SW  = NCS > 1 ? $clog2(NCS) : 1;
  state_t st;
  logic miso_s, tick, pend, same, load, samp, last, tbit, fb;
  logic cpol_r, cpha_r, lsb_r, hold_r;
  logic [SW-1:0] sel;
  logic [NBW-1:0] nb, ncl;
  logic [CSW-1:0] setup_r, wcnt;
  logic [EW-1:0] ecnt, e, ti;
  logic [MAXB-1:0] tx, rx, rx_nx, rx_f, qv, tx_sh, d_sh;
  spi_mc_tick_gen #(.DIVW(DIVW)) u_tick (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .div  (div),
    .tick (tick)
  );
  // single sync stage on the serial input (mosi when looped back)
`ifdef SPI_MASTER_MC_LOOPBACK_EN
  always_ff @(posedge clk) miso_s <= reset ? 1'b0 : (loopback ? mosi : miso);
`else
  always_ff @(posedge clk) miso_s <= reset ? 1'b0 : miso;
`endif
  // start/continue decisions, bit selection and receive-word alignment
  always_comb begin
    pend = req != ack;
    same = cs_sel == sel && cpol == cpol_r && cpha == cpha_r;
    load = pend && (st == IDLE || (st == HOLD && same));
    ncl = NBW'(clamp_nbits(int'(nbits), MAXB));
    d_sh = d >> (ncl - NBW'(1));
    fb = lsb_first ? d[0] : d_sh[0];
    e = ecnt + EW'(1);
    samp = e[0] ^ cpha_r;
    last = e == (EW'(nb) << 1);
    ti = lsb_r ? e >> 1 : EW'(nb) - (e >> 1) - EW'(1);
    tx_sh = tx >> ti;
    tbit = (e >> 1) < EW'(nb) && tx_sh[0];
    rx_nx = lsb_r ? {miso_s, rx[MAXB-1:1]} : {rx[MAXB-2:0], miso_s};
    rx_f = samp ? rx_nx : rx;
    qv = lsb_r ? rx_f >> (MAXB - int'(nb)) : rx_f;
  end
  // transfer FSM; every advance except a request pickup waits for a tick
  always_ff @(posedge clk)
    if (reset) begin
      st <= IDLE;
      sclk <= 1'b0;
      mosi <= 1'b0;
      cs_n <= '1;
      ack <= 1'b0;
      q <= '0;
      busy <= 1'b0;
      sel <= '0;
      cpol_r <= 1'b0;
      cpha_r <= 1'b0;
      lsb_r <= 1'b0;
      hold_r <= 1'b0;
      nb <= '0;
      setup_r <= '0;
      wcnt <= '0;
      ecnt <= '0;
      tx <= '0;
      rx <= '0;
    end else begin
      if (load) begin
        sel <= cs_sel;
        cpol_r <= cpol;
        cpha_r <= cpha;
        lsb_r <= lsb_first;
        hold_r <= hold_cs;
        nb <= ncl;
        setup_r <= cs_setup;
        tx <= d;
        rx <= '0;
        ecnt <= '0;
        wcnt <= '0;
        mosi <= fb;
      end
      case (st)
        IDLE:
          if (pend) begin
            sclk <= cpol;
            cs_n <= ~(NCS'(1) << cs_sel);
            busy <= 1'b1;
            st <= SETUP;
          end
        SETUP:
          if (tick) begin
            if (wcnt == setup_r) begin
              ecnt <= '0;
              st <= SHIFT;
            end else
              wcnt <= wcnt + 1'b1;
          end
        SHIFT:
          if (tick) begin
            sclk <= ~sclk;
            ecnt <= e;
            if (samp) rx <= rx_nx;
            else mosi <= tbit;
            if (last) begin
              q <= qv;
              ack <= req;
              st <= TAIL;
            end
          end
        TAIL:
          if (tick) begin
            mosi <= 1'b0;
            wcnt <= '0;
            if (hold_r) st <= HOLD;
            else begin
              cs_n <= '1;
              st <= GAP;
            end
          end
        HOLD:
          if (pend) begin
            if (same) st <= SHIFT;
            else begin
              cs_n <= '1;
              wcnt <= '0;
              st <= GAP;
            end
          end
        GAP:
          if (tick) begin
            if (wcnt == setup_r) begin
              busy <= 1'b0;
              st <= IDLE;
            end else
              wcnt <= wcnt + 1'b1;
          end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_master_mc.sv
// tb_spi_master_mc: random and directed SPI words against a slave model and a q/mosi scoreboard
module tb_spi_master_mc;
  typedef struct {
    logic [31:0] qe;
    logic [31:0] me;
    int nb;
    int sel;
  } exp_t;
  logic clk = 0, reset = 1, miso = 0, req = 0, cpol = 0, cpha = 0, lsb_first = 0, hold_cs = 0;
  logic sclk, mosi, ack, busy;
  logic [3:0] cs_n;
  logic [1:0] cs_sel = 0, cs_setup = 0;
  logic [5:0] nbits = 0;
  logic [7:0] div = 0;
  logic [31:0] d = 0, q;
`ifdef SPI_MASTER_MC_LOOPBACK_EN
  logic loopback = 1'b0;
`endif
  int checks = 0, errors = 0, issued = 0, acks = 0;
  int word_id = 0, cur_sel = 0, cur_nb = 8, cur_div = 0;
  logic cur_cpol = 0, cur_cpha = 0, cur_lsb = 0;
  logic [31:0] sd = 0;
  exp_t sb[$];
  int last_id = 0, scnt = 0, tcnt = 0, lastt = 0, cyc = 0;
  logic psclk = 0, pcs_low = 0, pack = 0;
  logic [31:0] mw = 0;
  exp_t ex;
  spi_master_mc dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .miso(miso),
`ifdef SPI_MASTER_MC_LOOPBACK_EN
    .loopback(loopback),
`endif
    .cs_n(cs_n), .req(req), .ack(ack), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .nbits(nbits), .div(div), .cs_setup(cs_setup),
    .hold_cs(hold_cs), .d(d), .q(q), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exv);
    end
  endfunction
  function automatic int clampn(input int n);
    return (n == 0 || n > 32) ? 32 : (n == 1 ? 2 : n);
  endfunction
  function automatic logic [31:0] maskn(input int n);
    return n >= 32 ? 32'hFFFF_FFFF : (32'h1 << n) - 32'h1;
  endfunction
  function automatic logic sbit(input int k);
    return sd[cur_lsb ? k : cur_nb - 1 - k];
  endfunction
  task automatic issue(input logic [1:0] sel, input logic pol, input logic pha, input logic lsb,
                       input int n, input int dv, input logic [1:0] setup, input logic hold,
                       input logic [31:0] dd, input logic [31:0] sdd);
    @(negedge clk);
    cur_sel = int'(sel);
    cur_cpol = pol;
    cur_cpha = pha;
    cur_lsb = lsb;
    cur_nb = clampn(n);
    cur_div = dv;
    sd = sdd;
    word_id++;
    cs_sel = sel;
    cpol = pol;
    cpha = pha;
    lsb_first = lsb;
    nbits = 6'(n);
    div = 8'(dv);
    cs_setup = setup;
    hold_cs = hold;
    d = dd;
    sb.push_back('{sdd & maskn(cur_nb), dd & maskn(cur_nb), cur_nb, cur_sel});
    issued++;
    @(negedge clk);
    @(negedge clk);
    req = ~req;
  endtask
  task automatic wait_ack();
    for (int i = 0; i < 20000 && ack != req; i++) @(negedge clk);
    chk("ack_timeout", 32'(ack), 32'(req));
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 20000 && busy; i++) @(negedge clk);
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask
  // slave model plus scoreboard monitor, evaluated away from the active edge
  always @(negedge clk) begin
    cyc++;
    chk("cs_onehot", 32'($countones(~cs_n) <= 1), 32'd1);
    if (!reset) begin
      if (word_id != last_id) begin
        last_id = word_id;
        scnt = 0;
        tcnt = 0;
        mw = 0;
        miso = sbit(0);
      end else if (sclk != psclk && pcs_low && !cs_n[cur_sel]) begin
        tcnt++;
        if (tcnt > 1) chk("sclk_half_period", 32'(cyc - lastt), 32'(cur_div + 1));
        lastt = cyc;
        if (((sclk != cur_cpol) ^ cur_cpha) && scnt < cur_nb) begin
          mw[cur_lsb ? scnt : cur_nb - 1 - scnt] = mosi;
          scnt++;
          miso = scnt < cur_nb ? sbit(scnt) : 1'b0;
        end
      end
      if (ack != pack) begin
        acks++;
        if (sb.size() == 0) chk("unexpected_ack", 32'(ack), 32'(pack));
        else begin
          ex = sb.pop_front();
          chk("q_word", q, ex.qe);
          chk("mosi_word", mw, ex.me);
          chk("bit_count", 32'(scnt), 32'(ex.nb));
          chk("cs_active_at_ack", 32'(cs_n[ex.sel]), 32'd0);
        end
      end
    end
    psclk = sclk;
    pcs_low = !cs_n[cur_sel];
    pack = ack;
  end
  initial begin
    logic hl;
    repeat (3) @(negedge clk);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'hF);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 0;
    issue(2'd1, 1'b0, 1'b0, 1'b0, 16, 1, 2'd0, 1'b0, $urandom, $urandom);
    for (int i = 0; i < 5000 && tcnt < 5; i++) @(negedge clk);
    chk("edge5_reached", 32'(tcnt >= 5), 32'd1);
    reset = 1;
    req = 0;
    @(negedge clk);
    chk("abort_cs_n", 32'(cs_n), 32'hF);
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ack", 32'(ack), 32'd0);
    reset = 0;
    sb.delete();
    issued--;
    repeat (3) @(negedge clk);
    issue(2'd0, 1'b0, 1'b0, 1'b0, 8, 3, 2'd1, 1'b0, 32'hA5, 32'h3C);
    wait_ack();
    wait_idle();
    chk("mode0_cs_released", 32'(cs_n), 32'hF);
    issue(2'd1, 1'b1, 1'b1, 1'b1, 12, 2, 2'd0, 1'b0, 32'h123, 32'h123);
    wait_ack();
    wait_idle();
    chk("mode3_idle_sclk", 32'(sclk), 32'd1);
    for (int i = 0; i < 3; i++) begin
      issue(2'd2, 1'b0, 1'b1, 1'b0, 8, 1, 2'd2, i < 2, $urandom, $urandom);
      wait_ack();
      if (i < 2) begin
        repeat (4) @(negedge clk);
        chk("burst_cs_held", 32'(cs_n), 32'hB);
      end
    end
    wait_idle();
    chk("burst_cs_released", 32'(cs_n), 32'hF);
    issue(2'd0, 1'b0, 1'b0, 1'b0, 8, 0, 2'd1, 1'b1, $urandom, $urandom);
    wait_ack();
    repeat (3) @(negedge clk);
    chk("hold_cs0", 32'(cs_n), 32'hE);
    issue(2'd1, 1'b0, 1'b0, 1'b0, 8, 0, 2'd1, 1'b0, $urandom, $urandom);
    wait_ack();
    wait_idle();
    chk("switch_cs_released", 32'(cs_n), 32'hF);
    issue(2'd3, 1'b1, 1'b0, 1'b1, 0, 0, 2'd0, 1'b0, $urandom, $urandom);
    wait_ack();
    issue(2'd3, 1'b0, 1'b1, 1'b0, 1, 0, 2'd0, 1'b0, $urandom, $urandom);
    wait_ack();
    hl = 0;
    for (int i = 0; i < 30; i++) begin
      hl = 1'($urandom_range(0, 1));
      issue(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 40)), int'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), hl, $urandom, $urandom);
      wait_ack();
    end
    if (hl) begin
      issue(cs_sel, cpol, cpha, 1'b0, 8, 1, 2'd0, 1'b0, $urandom, $urandom);
      wait_ack();
    end
    wait_idle();
    chk("final_cs_released", 32'(cs_n), 32'hF);
    repeat (2) @(negedge clk);
    chk("ack_count", 32'(acks), 32'(issued));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
